// File: rtl/filter_output_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : filter_output_arbiter_if
// Description : Bundles the filter-side pair inputs, force-pipeline
//               handshake and selected-pair outputs of the filter output
//               arbiter. slave = arbiter view, master = surrounding logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface filter_output_arbiter_if #(
    parameter int NUM_FILTERS          = 8,
    parameter int POS_PKT_STRUCT_WIDTH = 32,
    parameter int NODE_ID_WIDTH        = 8,
    parameter int PARTICLE_ID_WIDTH    = 10
);
    logic [NUM_FILTERS-1:0]                           i_filter_pair_valid;
    logic [NUM_FILTERS-1:0][POS_PKT_STRUCT_WIDTH-1:0] i_filter_nb_data;
    logic [NUM_FILTERS-1:0][NODE_ID_WIDTH-1:0]        i_filter_node_id;
    logic [NUM_FILTERS-1:0][PARTICLE_ID_WIDTH-1:0]    i_filter_home_parid;
    logic                                             i_force_ready;
    logic                                             i_nb_broadcast_done;
    logic [NUM_FILTERS-1:0]                           o_filter_buf_almost_full;
    logic [NUM_FILTERS-1:0]                           o_filter_output_arb_result;
    logic                                             o_pair_selected_valid;
    logic [POS_PKT_STRUCT_WIDTH-1:0]                  o_nb_selected;
    logic [NODE_ID_WIDTH-1:0]                         o_node_id_selected;
    logic [PARTICLE_ID_WIDTH-1:0]                     o_home_selected_parid;
    logic                                             o_nb_reg_release_flag;
    logic                                             o_overflow_err;
    logic                                             o_protocol_err;

    modport slave (
        input  i_filter_pair_valid, i_filter_nb_data, i_filter_node_id,
               i_filter_home_parid, i_force_ready, i_nb_broadcast_done,
        output o_filter_buf_almost_full, o_filter_output_arb_result,
               o_pair_selected_valid, o_nb_selected, o_node_id_selected,
               o_home_selected_parid, o_nb_reg_release_flag,
               o_overflow_err, o_protocol_err
    );

    modport master (
        output i_filter_pair_valid, i_filter_nb_data, i_filter_node_id,
               i_filter_home_parid, i_force_ready, i_nb_broadcast_done,
        input  o_filter_buf_almost_full, o_filter_output_arb_result,
               o_pair_selected_valid, o_nb_selected, o_node_id_selected,
               o_home_selected_parid, o_nb_reg_release_flag,
               o_overflow_err, o_protocol_err
    );
endinterface
`default_nettype wire

// File: rtl/filter_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : filter_output_arbiter
// Description : Per-filter pair buffers, round-robin pop toward the force
//               pipeline, registered selected-pair outputs and the drain FSM
//               that emits the neighbour-register release pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module filter_output_arbiter #(
    parameter int NUM_FILTERS          = 8,
    parameter int FILTER_BUF_DEPTH     = 8,
    parameter int FILTER_LATENCY       = 4,
    parameter int AF_MARGIN            = 5,
    parameter int POS_PKT_STRUCT_WIDTH = 32,
    parameter int NODE_ID_WIDTH        = 8,
    parameter int PARTICLE_ID_WIDTH    = 10
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    filter_output_arbiter_if.slave  bus
);
    localparam int PTR_W  = $clog2(FILTER_BUF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDX_W  = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int ENT_W  = POS_PKT_STRUCT_WIDTH + NODE_ID_WIDTH + PARTICLE_ID_WIDTH;
    localparam int AF_THR = FILTER_BUF_DEPTH - AF_MARGIN;
    localparam int LAT_W  = $clog2(FILTER_LATENCY + 2);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_PIPE = 2'd1;
    localparam logic [1:0] S_DRAIN     = 2'd2;
    localparam logic [1:0] S_RELEASE   = 2'd3;

    logic [NUM_FILTERS-1:0] nonempty_w;
    logic [NUM_FILTERS-1:0] pop_w;
    logic [NUM_FILTERS-1:0] ovf_w;
    logic [NUM_FILTERS-1:0] af_w;
    logic [ENT_W-1:0]       head_w [NUM_FILTERS];
    logic [IDX_W-1:0]       win_idx_w;
    logic                   any_grant_w;
    logic [ENT_W-1:0]       sel_entry_w;

    logic [IDX_W-1:0]                rr_q, rr_d;
    logic                            sel_valid_q;
    logic [POS_PKT_STRUCT_WIDTH-1:0] nb_sel_q;
    logic [NODE_ID_WIDTH-1:0]        node_sel_q;
    logic [PARTICLE_ID_WIDTH-1:0]    pid_sel_q;
    logic                            ovf_err_q;
    logic                            prot_err_q;
    logic [1:0]                      state_q, state_d;
    logic [LAT_W-1:0]                lat_cnt_q, lat_cnt_d;

    // Per-filter circular buffers; a full buffer still accepts a write when popped the same cycle
    for (genvar k = 0; k < NUM_FILTERS; k++) begin : g_buf
        logic [ENT_W-1:0] mem_q [FILTER_BUF_DEPTH];
        logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
        logic [CNT_W-1:0] count_q, count_d;
        logic             af_q;
        logic             full_w, push_w;

        assign full_w        = (count_q == CNT_W'(FILTER_BUF_DEPTH));
        assign push_w        = bus.i_filter_pair_valid[k] && (!full_w || pop_w[k]);
        assign ovf_w[k]      = bus.i_filter_pair_valid[k] && full_w && !pop_w[k];
        assign count_d       = count_q + CNT_W'(push_w) - CNT_W'(pop_w[k]);
        assign nonempty_w[k] = (count_q != '0);
        assign head_w[k]     = mem_q[rd_ptr_q];
        assign af_w[k]       = af_q;

        // Storage array carries no reset; validity is tracked by the counters
        always_ff @(posedge clk) begin
            if (push_w) begin
                mem_q[wr_ptr_q] <= {bus.i_filter_nb_data[k], bus.i_filter_node_id[k],
                                    bus.i_filter_home_parid[k]};
            end
        end

        // Pointer, occupancy and almost-full bookkeeping
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                af_q     <= 1'b0;
            end else begin
                if (push_w)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop_w[k]) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_d;
                af_q    <= (int'(count_d) >= AF_THR);
            end
        end
    end

    // Round-robin winner: first non-empty buffer at or above the pointer, wrapping
    always_comb begin
        int idx;
        idx         = 0;
        pop_w       = '0;
        win_idx_w   = '0;
        any_grant_w = 1'b0;
        rr_d        = rr_q;
        if (bus.i_force_ready) begin
            for (int i = 0; i < NUM_FILTERS; i++) begin
                idx = int'(rr_q) + i;
                if (idx >= NUM_FILTERS) idx = idx - NUM_FILTERS;
                if (!any_grant_w && nonempty_w[IDX_W'(idx)]) begin
                    any_grant_w = 1'b1;
                    win_idx_w   = IDX_W'(idx);
                end
            end
        end
        if (any_grant_w) begin
            pop_w[win_idx_w] = 1'b1;
            rr_d = (int'(win_idx_w) == NUM_FILTERS - 1) ? '0 : win_idx_w + IDX_W'(1);
        end
    end

    assign sel_entry_w = head_w[win_idx_w];

    // Drain sequencing: wait out the filter pipeline, then for everything to leave
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_nb_broadcast_done) begin
                    state_d   = S_WAIT_PIPE;
                    lat_cnt_d = LAT_W'(FILTER_LATENCY);
                end
            end
            S_WAIT_PIPE: begin
                // Leave on the cycle whose decrement reaches zero
                if (lat_cnt_q <= LAT_W'(1)) begin
                    state_d   = S_DRAIN;
                    lat_cnt_d = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            S_DRAIN: begin
                if (!(|nonempty_w) && !(|bus.i_filter_pair_valid) && !sel_valid_q)
                    state_d = S_RELEASE;
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Arbitration pointer, selected-pair registers, FSM and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= '0;
            sel_valid_q <= 1'b0;
            nb_sel_q    <= '0;
            node_sel_q  <= '0;
            pid_sel_q   <= '0;
            ovf_err_q   <= 1'b0;
            prot_err_q  <= 1'b0;
            state_q     <= S_IDLE;
            lat_cnt_q   <= '0;
        end else begin
            rr_q        <= rr_d;
            sel_valid_q <= any_grant_w;
            if (any_grant_w) begin
                nb_sel_q   <= sel_entry_w[ENT_W-1 -: POS_PKT_STRUCT_WIDTH];
                node_sel_q <= sel_entry_w[PARTICLE_ID_WIDTH +: NODE_ID_WIDTH];
                pid_sel_q  <= sel_entry_w[0 +: PARTICLE_ID_WIDTH];
            end
            if (|ovf_w) ovf_err_q <= 1'b1;
            if (bus.i_nb_broadcast_done && (state_q != S_IDLE)) prot_err_q <= 1'b1;
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign bus.o_filter_buf_almost_full   = af_w;
    assign bus.o_filter_output_arb_result = pop_w;
    assign bus.o_pair_selected_valid      = sel_valid_q;
    assign bus.o_nb_selected              = nb_sel_q;
    assign bus.o_node_id_selected         = node_sel_q;
    assign bus.o_home_selected_parid      = pid_sel_q;
    assign bus.o_nb_reg_release_flag      = (state_q == S_RELEASE);
    assign bus.o_overflow_err             = ovf_err_q;
    assign bus.o_protocol_err             = prot_err_q;
endmodule
`default_nettype wire

// File: tb/tb_filter_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_filter_output_arbiter
// Description : Directed self-checking bench for filter_output_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_output_arbiter;
    localparam int NF  = 8;
    localparam int DEP = 8;
    localparam int FL  = 4;
    localparam int AFM = 5;
    localparam int PW  = 32;
    localparam int NW  = 8;
    localparam int HW  = 10;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   pulses;

    filter_output_arbiter_if #(
        .NUM_FILTERS(NF), .POS_PKT_STRUCT_WIDTH(PW),
        .NODE_ID_WIDTH(NW), .PARTICLE_ID_WIDTH(HW)
    ) bus ();

    filter_output_arbiter #(
        .NUM_FILTERS(NF), .FILTER_BUF_DEPTH(DEP), .FILTER_LATENCY(FL),
        .AF_MARGIN(AFM), .POS_PKT_STRUCT_WIDTH(PW), .NODE_ID_WIDTH(NW),
        .PARTICLE_ID_WIDTH(HW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_filter_pair_valid = '0;
        bus.i_filter_nb_data    = '0;
        bus.i_filter_node_id    = '0;
        bus.i_filter_home_parid = '0;
        bus.i_nb_broadcast_done = 1'b0;
    endtask

    task automatic put(input int k, input logic [PW-1:0] nb, input logic [NW-1:0] nid,
                       input logic [HW-1:0] hid);
        bus.i_filter_pair_valid[k] = 1'b1;
        bus.i_filter_nb_data[k]    = nb;
        bus.i_filter_node_id[k]    = nid;
        bus.i_filter_home_parid[k] = hid;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        bus.i_force_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        bus.i_force_ready = 1'b0;
        #2;
        // Reset state
        chk("rst_grant",    64'(bus.o_filter_output_arb_result), 64'h0);
        chk("rst_selvalid", 64'(bus.o_pair_selected_valid), 64'h0);
        chk("rst_nb",       64'(bus.o_nb_selected), 64'h0);
        chk("rst_release",  64'(bus.o_nb_reg_release_flag), 64'h0);
        chk("rst_ovf",      64'(bus.o_overflow_err), 64'h0);
        chk("rst_prot",     64'(bus.o_protocol_err), 64'h0);
        chk("rst_af",       64'(bus.o_filter_buf_almost_full), 64'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single pair through filter 3
        bus.i_force_ready = 1'b1;
        put(3, 32'hA3A3_0003, 8'h13, 10'h033);
        settle();
        chk("t1_grant_same_cycle", 64'(bus.o_filter_output_arb_result), 64'h0);
        tick();
        clear_inputs();
        settle();
        chk("t1_grant", 64'(bus.o_filter_output_arb_result), 64'h08);
        chk("t1_selvalid_early", 64'(bus.o_pair_selected_valid), 64'h0);
        tick();
        chk("t1_selvalid", 64'(bus.o_pair_selected_valid), 64'h1);
        chk("t1_nb",   64'(bus.o_nb_selected), 64'hA3A3_0003);
        chk("t1_node", 64'(bus.o_node_id_selected), 64'h13);
        chk("t1_pid",  64'(bus.o_home_selected_parid), 64'h033);

        // Filters 0, 2, 7 together, round-robin from pointer 0
        do_reset();
        bus.i_force_ready = 1'b1;
        put(0, 32'h0000_00A0, 8'h20, 10'h100);
        put(2, 32'h0000_00A2, 8'h22, 10'h102);
        put(7, 32'h0000_00A7, 8'h27, 10'h107);
        tick();
        clear_inputs();
        settle();
        chk("t2_grant0", 64'(bus.o_filter_output_arb_result), 64'h01);
        tick();
        chk("t2_grant2", 64'(bus.o_filter_output_arb_result), 64'h04);
        chk("t2_nb0",    64'(bus.o_nb_selected), 64'hA0);
        tick();
        chk("t2_grant7", 64'(bus.o_filter_output_arb_result), 64'h80);
        chk("t2_nb2",    64'(bus.o_nb_selected), 64'hA2);
        tick();
        chk("t2_grant_none", 64'(bus.o_filter_output_arb_result), 64'h00);
        chk("t2_nb7",        64'(bus.o_nb_selected), 64'hA7);
        chk("t2_pid7",       64'(bus.o_home_selected_parid), 64'h107);
        tick();
        chk("t2_selvalid_low", 64'(bus.o_pair_selected_valid), 64'h0);
        chk("t2_nb_hold",      64'(bus.o_nb_selected), 64'hA7);
        // Pointer wrapped to 0: filter 1 must win over filter 7
        put(7, 32'h0000_00B7, 8'h37, 10'h117);
        put(1, 32'h0000_00B1, 8'h31, 10'h111);
        tick();
        clear_inputs();
        settle();
        chk("t2_wrap_grant1", 64'(bus.o_filter_output_arb_result), 64'h02);
        tick();
        chk("t2_wrap_grant7", 64'(bus.o_filter_output_arb_result), 64'h80);
        tick();
        chk("t2_wrap_none", 64'(bus.o_filter_output_arb_result), 64'h00);

        // Fill filter 1 with ready low; 9th write overflows
        do_reset();
        for (int i = 0; i < 9; i++) begin
            put(1, PW'(100 + i), NW'(i), HW'(i));
            settle();
            chk("t3_af", 64'(bus.o_filter_buf_almost_full[1]), 64'(i >= 3));
            chk("t3_ovf_low", 64'(bus.o_overflow_err), 64'h0);
            tick();
        end
        clear_inputs();
        settle();
        chk("t3_ovf_set", 64'(bus.o_overflow_err), 64'h1);
        bus.i_force_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            settle();
            chk("t3_drain_grant", 64'(bus.o_filter_output_arb_result), 64'h02);
            tick();
            chk("t3_drain_nb", 64'(bus.o_nb_selected), 64'(100 + j));
        end
        settle();
        chk("t3_ninth_dropped", 64'(bus.o_filter_output_arb_result), 64'h00);
        chk("t3_ovf_sticky",    64'(bus.o_overflow_err), 64'h1);

        // Done pulse with empty buffers: release FL+2 cycles later
        do_reset();
        bus.i_force_ready = 1'b1;
        bus.i_nb_broadcast_done = 1'b1;
        settle();
        chk("t4_rel_t0", 64'(bus.o_nb_reg_release_flag), 64'h0);
        tick();
        bus.i_nb_broadcast_done = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            settle();
            chk("t4_release", 64'(bus.o_nb_reg_release_flag), 64'(i == FL + 2));
            tick();
        end
        // Two pairs arrive during WAIT_PIPE and delay the release
        bus.i_nb_broadcast_done = 1'b1;
        tick();
        bus.i_nb_broadcast_done = 1'b0;
        tick();
        put(4, 32'h0000_00C4, 8'h44, 10'h144);
        put(5, 32'h0000_00C5, 8'h45, 10'h145);
        tick();
        clear_inputs();
        settle();
        chk("t4b_grant4", 64'(bus.o_filter_output_arb_result), 64'h10);
        chk("t4b_rel_3",  64'(bus.o_nb_reg_release_flag), 64'h0);
        tick();
        chk("t4b_grant5", 64'(bus.o_filter_output_arb_result), 64'h20);
        chk("t4b_rel_4",  64'(bus.o_nb_reg_release_flag), 64'h0);
        tick();
        chk("t4b_selvalid_5", 64'(bus.o_pair_selected_valid), 64'h1);
        chk("t4b_nb5",        64'(bus.o_nb_selected), 64'hC5);
        chk("t4b_rel_5",      64'(bus.o_nb_reg_release_flag), 64'h0);
        tick();
        chk("t4b_rel_6", 64'(bus.o_nb_reg_release_flag), 64'h0);
        tick();
        chk("t4b_rel_7", 64'(bus.o_nb_reg_release_flag), 64'h1);
        tick();
        chk("t4b_rel_8", 64'(bus.o_nb_reg_release_flag), 64'h0);

        // Second done pulse during DRAIN
        bus.i_nb_broadcast_done = 1'b1;
        tick();
        bus.i_nb_broadcast_done = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.i_nb_broadcast_done = 1'b1;
        settle();
        chk("t5_prot_before", 64'(bus.o_protocol_err), 64'h0);
        tick();
        bus.i_nb_broadcast_done = 1'b0;
        chk("t5_prot_set", 64'(bus.o_protocol_err), 64'h1);
        chk("t5_release",  64'(bus.o_nb_reg_release_flag), 64'h1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.o_nb_reg_release_flag) pulses++;
        end
        chk("t5_extra_release", 64'(pulses), 64'h0);
        chk("t5_prot_sticky",   64'(bus.o_protocol_err), 64'h1);

        // Asynchronous reset mid-DRAIN with 3 buffered pairs
        bus.i_force_ready = 1'b0;
        put(0, 32'h0000_00D0, 8'h50, 10'h150);
        put(1, 32'h0000_00D1, 8'h51, 10'h151);
        put(2, 32'h0000_00D2, 8'h52, 10'h152);
        bus.i_nb_broadcast_done = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i < 5; i++) tick();
        chk("t6_no_release_pre", 64'(bus.o_nb_reg_release_flag), 64'h0);
        rst_n = 1'b0;
        bus.i_force_ready = 1'b1;
        settle();
        chk("t6_grant",    64'(bus.o_filter_output_arb_result), 64'h0);
        chk("t6_selvalid", 64'(bus.o_pair_selected_valid), 64'h0);
        chk("t6_nb",       64'(bus.o_nb_selected), 64'h0);
        chk("t6_node",     64'(bus.o_node_id_selected), 64'h0);
        chk("t6_pid",      64'(bus.o_home_selected_parid), 64'h0);
        chk("t6_release",  64'(bus.o_nb_reg_release_flag), 64'h0);
        chk("t6_ovf",      64'(bus.o_overflow_err), 64'h0);
        chk("t6_prot",     64'(bus.o_protocol_err), 64'h0);
        chk("t6_af",       64'(bus.o_filter_buf_almost_full), 64'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("t6_post_grant",   64'(bus.o_filter_output_arb_result), 64'h0);
            chk("t6_post_release", 64'(bus.o_nb_reg_release_flag), 64'h0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
